// File: rtl/ycbcr_skin_seg_if.sv
// Pixel stream bundle for ycbcr_skin_seg: the RGB input side and the segmented output side.
// Valid-only streaming: a beat transfers on every rising edge where *_valid is high;
// there is no ready, so the sink must accept every beat and sof/eof are meaningful only with valid.
interface skin_seg_if #(
  parameter int PW = 12
);
  logic          in_valid;
  logic [PW-1:0] in_pixel;
  logic          in_sof;
  logic          in_eof;
  logic          out_valid;
  logic [PW-1:0] out_pixel;
  logic          out_sof;
  logic          out_eof;

  modport master (
    output in_valid, in_pixel, in_sof, in_eof,
    input  out_valid, out_pixel, out_sof, out_eof
  );

  modport slave (
    input  in_valid, in_pixel, in_sof, in_eof,
    output out_valid, out_pixel, out_sof, out_eof
  );
endinterface

// File: rtl/ycbcr_skin_seg.sv
// Three-stage RGB->YCbCr skin segmenter with frame-synchronous saturating threshold edits.
// Optional skin-pixel statistics are built only when SKIN_SEG_STATS_EN is defined.
module ycbcr_skin_seg #(
  parameter int CH_W       = 4,
  parameter int STEP       = 1,
  parameter int CNT_W      = 20,
  parameter int Y_LO_INIT  = 50,
  parameter int Y_HI_INIT  = 255,
  parameter int CB_LO_INIT = 77,
  parameter int CB_HI_INIT = 132,
  parameter int CR_LO_INIT = 135,
  parameter int CR_HI_INIT = 173
) (
  input  logic             clk,
  input  logic             rst_n,
  skin_seg_if.slave        io_pix,
  input  logic             i_mode,
  input  logic             i_th_sel,
  input  logic             i_th_inc,
  input  logic             i_th_dec,
  output logic [2:0]       o_sel_idx,
  output logic [CNT_W-1:0] o_skin_count,
  output logic             o_count_valid
);
  localparam int PW = 3 * CH_W;
  localparam logic [7:0] TH_INIT [6] = '{8'(Y_LO_INIT), 8'(Y_HI_INIT), 8'(CB_LO_INIT),
                                         8'(CB_HI_INIT), 8'(CR_LO_INIT), 8'(CR_HI_INIT)};

  logic [7:0] w_r8, w_g8, w_b8;
  always_comb begin
    w_r8 = 8'(io_pix.in_pixel[PW-1 -: CH_W]) << (8 - CH_W);
    w_g8 = 8'(io_pix.in_pixel[2*CH_W-1 -: CH_W]) << (8 - CH_W);
    w_b8 = 8'(io_pix.in_pixel[CH_W-1:0]) << (8 - CH_W);
  end

  // Stage 1: the nine coefficient products
  logic          r1_valid, r1_sof, r1_eof;
  logic [PW-1:0] r1_pix;
  logic [15:0]   r1_yr, r1_yg, r1_yb, r1_br, r1_bg, r1_bb, r1_rr, r1_rg, r1_rb;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_sof   <= 1'b0;
      r1_eof   <= 1'b0;
      r1_pix   <= '0;
      r1_yr    <= '0;
      r1_yg    <= '0;
      r1_yb    <= '0;
      r1_br    <= '0;
      r1_bg    <= '0;
      r1_bb    <= '0;
      r1_rr    <= '0;
      r1_rg    <= '0;
      r1_rb    <= '0;
    end else begin
      r1_valid <= io_pix.in_valid;
      r1_sof   <= io_pix.in_valid && io_pix.in_sof;
      r1_eof   <= io_pix.in_valid && io_pix.in_eof;
      r1_pix   <= io_pix.in_pixel;
      r1_yr    <= 16'(w_r8) * 16'd77;
      r1_yg    <= 16'(w_g8) * 16'd150;
      r1_yb    <= 16'(w_b8) * 16'd29;
      r1_br    <= 16'(w_r8) * 16'd43;
      r1_bg    <= 16'(w_g8) * 16'd85;
      r1_bb    <= 16'(w_b8) * 16'd128;
      r1_rr    <= 16'(w_r8) * 16'd128;
      r1_rg    <= 16'(w_g8) * 16'd107;
      r1_rb    <= 16'(w_b8) * 16'd21;
    end
  end

  function automatic logic [7:0] clamp8(input logic signed [18:0] v);
    logic signed [18:0] s;
    s = v >>> 8;
    if (s < 19'sd0)        return 8'd0;
    else if (s > 19'sd255) return 8'hff;
    else                   return s[7:0];
  endfunction

  // Stage 2: signed sums with chroma offset, then shift and clamp
  logic signed [18:0] w_ys, w_cbs, w_crs;
  always_comb begin
    w_ys  = 19'(r1_yr) + 19'(r1_yg) + 19'(r1_yb);
    w_cbs = 19'(r1_bb) - 19'(r1_br) - 19'(r1_bg) + 19'sd32768;
    w_crs = 19'(r1_rr) - 19'(r1_rg) - 19'(r1_rb) + 19'sd32768;
  end

  logic          r2_valid, r2_sof, r2_eof;
  logic [PW-1:0] r2_pix;
  logic [7:0]    r2_y, r2_cb, r2_cr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
      r2_sof   <= 1'b0;
      r2_eof   <= 1'b0;
      r2_pix   <= '0;
      r2_y     <= '0;
      r2_cb    <= '0;
      r2_cr    <= '0;
    end else begin
      r2_valid <= r1_valid;
      r2_sof   <= r1_sof;
      r2_eof   <= r1_eof;
      r2_pix   <= r1_pix;
      r2_y     <= clamp8(w_ys);
      r2_cb    <= clamp8(w_cbs);
      r2_cr    <= clamp8(w_crs);
    end
  end

  // Threshold edit path: working set is edited, active set is copied at sof
  logic [7:0] r_wk  [6];
  logic [7:0] r_act [6];
  logic       r_act_mode;
  logic [2:0] r_sel;
  logic [7:0] w_cur, w_inc_sat, w_dec_sat;
  logic [8:0] w_inc_v;
  logic       w_load;
  always_comb begin
    w_cur     = r_wk[r_sel];
    w_inc_v   = {1'b0, w_cur} + 9'(STEP);
    w_inc_sat = w_inc_v[8] ? 8'hff : w_inc_v[7:0];
    w_dec_sat = (w_cur < 8'(STEP)) ? 8'd0 : w_cur - 8'(STEP);
    w_load    = r2_valid && r2_sof;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        r_wk[i]  <= TH_INIT[i];
        r_act[i] <= TH_INIT[i];
      end
      r_sel      <= 3'd0;
      r_act_mode <= 1'b0;
    end else begin
      if (i_th_inc && !i_th_dec)      r_wk[r_sel] <= w_inc_sat;
      else if (i_th_dec && !i_th_inc) r_wk[r_sel] <= w_dec_sat;
      if (i_th_sel) r_sel <= (r_sel == 3'd5) ? 3'd0 : r_sel + 3'd1;
      // The copy sees the working set before this cycle's edit
      if (w_load) begin
        for (int i = 0; i < 6; i++) r_act[i] <= r_wk[i];
        r_act_mode <= i_mode;
      end
    end
  end

  // Stage 3: the sof pixel is judged with the freshly loaded set
  logic [7:0] w_th [6];
  logic       w_mode, w_skin;
  always_comb begin
    for (int i = 0; i < 6; i++) w_th[i] = w_load ? r_wk[i] : r_act[i];
    w_mode = w_load ? i_mode : r_act_mode;
    w_skin = (w_th[4] < r2_cr) && (r2_cr < w_th[5]) &&
             (w_th[2] < r2_cb) && (r2_cb < w_th[3]) &&
             (w_th[0] <= r2_y) && (r2_y <= w_th[1]);
  end

  logic          r_out_valid, r_out_sof, r_out_eof;
  logic [PW-1:0] r_out_pixel;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_out_pixel <= '0;
    end else begin
      r_out_valid <= r2_valid;
      r_out_sof   <= r2_valid && r2_sof;
      r_out_eof   <= r2_valid && r2_eof;
      r_out_pixel <= (r2_valid && w_skin) ? (w_mode ? r2_pix : {PW{1'b1}}) : '0;
    end
  end

  assign io_pix.out_valid = r_out_valid;
  assign io_pix.out_sof   = r_out_sof;
  assign io_pix.out_eof   = r_out_eof;
  assign io_pix.out_pixel = r_out_pixel;
  assign o_sel_idx        = r_sel;

`ifdef SKIN_SEG_STATS_EN
  // Counted alongside stage 3 so the publish lands on the eof output cycle
  logic [CNT_W-1:0] r_cnt, r_skin_count, w_cnt_base, w_cnt_next;
  logic             r_count_valid;
  always_comb begin
    w_cnt_base = r2_sof ? '0 : r_cnt;
    w_cnt_next = (w_skin && (w_cnt_base != {CNT_W{1'b1}})) ? w_cnt_base + CNT_W'(1) : w_cnt_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_skin_count  <= '0;
      r_count_valid <= 1'b0;
    end else begin
      r_count_valid <= 1'b0;
      if (r2_valid) begin
        if (r2_eof) begin
          r_skin_count  <= w_cnt_next;
          r_count_valid <= 1'b1;
          r_cnt         <= '0;
        end else begin
          r_cnt <= w_cnt_next;
        end
      end
    end
  end

  assign o_skin_count  = r_skin_count;
  assign o_count_valid = r_count_valid;
`else
  assign o_skin_count  = '0;
  assign o_count_valid = 1'b0;
`endif
endmodule
